// File: rtl/morse_seq_buffer.sv
// Morse message buffer: builds characters from dot/dash strobes and appends
// them, plus word-space entries, to a packed slot store frozen on Enter.
module morse_seq_buffer #(
  parameter int SLOTS   = 16,
  parameter int MAX_SYM = 5,
  localparam int SEQ_W  = 2 * MAX_SYM,
  localparam int CNT_W  = $clog2(SLOTS + 1)
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Dot,
  input  logic                     Dash,
  input  logic                     Space,
  input  logic                     EndSeq,
  input  logic                     Enter,
  input  logic                     Clear,
  output logic [SLOTS*SEQ_W-1:0]   o_sequence,
  output logic [CNT_W-1:0]         o_count,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_ovf,
  output logic                     o_err_long
);

  localparam int SYM_W = $clog2(MAX_SYM + 1);
  localparam logic [SEQ_W-1:0] WORD_SPACE = '1;
  localparam logic [1:0] CODE_DOT  = 2'b01;
  localparam logic [1:0] CODE_DASH = 2'b10;

  typedef enum logic [1:0] {IDLE, BUILD, SPACE_PEND, DONE} state_t;

  state_t           state;
  logic [SEQ_W-1:0] builder;
  logic [SYM_W-1:0] sym_cnt;

  logic             commit_req;
  logic [SEQ_W-1:0] commit_data;
  logic             sym_req;
  logic [1:0]       sym_code;

  // Strobe decode in priority order; Clear is handled directly by the register block.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    commit_req  = 1'b0;
    commit_data = builder;
    sym_req     = 1'b0;
    sym_code    = CODE_DOT;
    if (!Clear) begin
      case (state)
        IDLE, BUILD: begin
          if (Enter || EndSeq) begin
            commit_req = (state == BUILD);
          end else if (Space) begin
            commit_req = 1'b1;
            if (state == IDLE) commit_data = WORD_SPACE;
          end else if (Dash) begin
            sym_req  = 1'b1;
            sym_code = CODE_DASH;
          end else if (Dot) begin
            sym_req = 1'b1;
          end
        end
        SPACE_PEND: begin
          commit_req  = 1'b1;
          commit_data = WORD_SPACE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: synchronous reset; the slot store is ordinary flops and must be
  // cleared here, since Clear and reset both promise an all-zero view.
  // NOTE: non-blocking assignments only, so every branch sees pre-edge state.
  always_ff @(posedge Clk) begin
    if (!Reset_n || Clear) begin
      state      <= IDLE;
      builder    <= '0;
      sym_cnt    <= '0;
      o_sequence <= '0;
      o_count    <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_ovf      <= 1'b0;
      o_err_long <= 1'b0;
    end else begin
      if (commit_req) begin
        if (o_count == CNT_W'(SLOTS)) begin
          o_ovf <= 1'b1;
        end else begin
          for (int i = 0; i < SLOTS; i++) begin
            if (o_count == CNT_W'(i)) o_sequence[(SLOTS-1-i)*SEQ_W +: SEQ_W] <= commit_data;
          end
          o_count <= o_count + CNT_W'(1);
        end
      end

      case (state)
        IDLE, BUILD: begin
          if (Enter) begin
            builder <= '0;
            sym_cnt <= '0;
            o_valid <= 1'b1;
            state   <= DONE;
          end else if (EndSeq) begin
            builder <= '0;
            sym_cnt <= '0;
            state   <= IDLE;
          end else if (Space) begin
            if (state == BUILD) begin
              builder <= '0;
              sym_cnt <= '0;
              o_busy  <= 1'b1;
              state   <= SPACE_PEND;
            end
          end else if (sym_req) begin
            // A full builder drops the symbol but keeps the character intact.
            if (sym_cnt < SYM_W'(MAX_SYM)) begin
              for (int j = 0; j < MAX_SYM; j++) begin
                if (sym_cnt == SYM_W'(j)) builder[SEQ_W-1-2*j -: 2] <= sym_code;
              end
              sym_cnt <= sym_cnt + SYM_W'(1);
              state   <= BUILD;
            end else begin
              o_err_long <= 1'b1;
            end
          end
        end
        SPACE_PEND: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_seq_buffer.sv
// Directed bench for morse_seq_buffer: expected slot codes are queued as
// stimulus is driven and popped against the store when it is inspected.
module tb_morse_seq_buffer;

  localparam int SLOTS = 16;
  localparam int SEQ_W = 10;
  localparam int SW    = SLOTS * SEQ_W;

  localparam logic [5:0] DOT  = 6'b000001;
  localparam logic [5:0] DASH = 6'b000010;
  localparam logic [5:0] SPC  = 6'b000100;
  localparam logic [5:0] ENDS = 6'b001000;
  localparam logic [5:0] ENT  = 6'b010000;
  localparam logic [5:0] CLR  = 6'b100000;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Dot, Dash, Space, EndSeq, Enter, Clear;
  logic [SW-1:0] o_sequence;
  logic [4:0]    o_count;
  logic          o_valid, o_busy, o_ovf, o_err_long;

  int errors = 0;
  int checks = 0;
  logic [SEQ_W-1:0] exp_q[$];

  morse_seq_buffer #(.SLOTS(16), .MAX_SYM(5)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Dot        (Dot),
    .Dash       (Dash),
    .Space      (Space),
    .EndSeq     (EndSeq),
    .Enter      (Enter),
    .Clear      (Clear),
    .o_sequence (o_sequence),
    .o_count    (o_count),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_ovf      (o_ovf),
    .o_err_long (o_err_long)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one strobe pattern across a single rising edge; returns at the
  // following falling edge, where outputs are sampled.
  task automatic cyc(input logic [5:0] s);
    {Clear, Enter, EndSeq, Space, Dash, Dot} = s;
    @(negedge Clk);
    {Clear, Enter, EndSeq, Space, Dash, Dot} = '0;
  endtask

  task automatic cyc_n(input logic [5:0] s, input int n);
    for (int k = 0; k < n; k++) cyc(s);
  endtask

  task automatic pulse_reset();
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  function automatic logic [SEQ_W-1:0] slot(input int i);
    return o_sequence[(SLOTS-1-i)*SEQ_W +: SEQ_W];
  endfunction

  // Pop every queued expectation into slots 0..n-1; remaining slots must be zero.
  task automatic check_store(input string tag);
    logic [SW-1:0]    expv;
    logic [SEQ_W-1:0] code;
    int n;
    expv = '0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      code = exp_q.pop_front();
      expv[(SLOTS-1-i)*SEQ_W +: SEQ_W] = code;
      check($sformatf("%s_slot%0d", tag, i), SW'(slot(i)), SW'(code));
    end
    check($sformatf("%s_store", tag), o_sequence, expv);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_seq"},   o_sequence,      '0);
    check({tag, "_count"}, SW'(o_count),    '0);
    check({tag, "_valid"}, SW'(o_valid),    '0);
    check({tag, "_busy"},  SW'(o_busy),     '0);
    check({tag, "_ovf"},   SW'(o_ovf),      '0);
    check({tag, "_err"},   SW'(o_err_long), '0);
  endtask

  initial begin
    Reset_n = 1'b0;
    {Clear, Enter, EndSeq, Space, Dash, Dot} = '0;
    repeat (2) @(negedge Clk);
    check_zero_outputs("reset");
    Reset_n = 1'b1;

    // Four-entry message with a word space, then Enter.
    cyc(DOT); cyc(DASH); cyc(ENDS);                       exp_q.push_back(10'h180);
    cyc(DASH); cyc_n(DOT, 3); cyc(ENDS);                  exp_q.push_back(10'h254);
    cyc(SPC);                                             exp_q.push_back(10'h3FF);
    cyc(DOT); cyc_n(DASH, 4); cyc(ENDS);                  exp_q.push_back(10'h1AA);
    check("msg_valid_before_enter", SW'(o_valid), '0);
    cyc(ENT);
    check("msg_valid_after_enter", SW'(o_valid), SW'(1));
    check("msg_count", SW'(o_count), SW'(4));
    check_store("msg");

    // DONE ignores symbols; the store stays frozen.
    cyc(DOT); cyc(ENDS); cyc(SPC);
    exp_q.push_back(10'h180); exp_q.push_back(10'h254);
    exp_q.push_back(10'h3FF); exp_q.push_back(10'h1AA);
    check("done_valid_hold", SW'(o_valid), SW'(1));
    check("done_count_frozen", SW'(o_count), SW'(4));
    check_store("done_frozen");

    cyc(CLR);
    check("clear_count", SW'(o_count), '0);
    check("clear_valid", SW'(o_valid), '0);
    check("clear_seq", o_sequence, '0);

    // Space in BUILD: letter now, word space one cycle later, Dot ignored.
    cyc(DASH); cyc(DOT); cyc(SPC);
    check("spc_busy_on", SW'(o_busy), SW'(1));
    check("spc_count_letter", SW'(o_count), SW'(1));
    cyc(DOT);
    check("spc_busy_off", SW'(o_busy), '0);
    check("spc_count_space", SW'(o_count), SW'(2));
    cyc(ENDS);
    check("spc_dot_ignored", SW'(o_count), SW'(2));
    exp_q.push_back(10'h240); exp_q.push_back(10'h3FF);
    check_store("spc");

    // Over-length character: sixth symbol dropped, sticky flag set.
    cyc(CLR);
    cyc_n(DOT, 5);
    check("long_err_at5", SW'(o_err_long), '0);
    cyc(DOT);
    check("long_err_at6", SW'(o_err_long), SW'(1));
    cyc(ENDS);                                            exp_q.push_back(10'h155);
    check("long_err_sticky", SW'(o_err_long), SW'(1));
    check_store("long");

    // Overflow: seventeenth character dropped, count saturates.
    cyc(CLR);
    check("ovf_clear_err", SW'(o_err_long), '0);
    for (int k = 0; k < 16; k++) begin
      cyc(DOT); cyc(ENDS); exp_q.push_back(10'h100);
    end
    check("ovf_count16", SW'(o_count), SW'(16));
    check("ovf_flag_before", SW'(o_ovf), '0);
    cyc(DOT); cyc(ENDS);
    check("ovf_flag_after", SW'(o_ovf), SW'(1));
    check("ovf_count_sat", SW'(o_count), SW'(16));
    cyc(ENT);
    check("ovf_valid", SW'(o_valid), SW'(1));
    check_store("ovf");

    // Reset mid-build discards the partial character.
    cyc(CLR);
    cyc(DASH);
    pulse_reset();
    check_zero_outputs("rst_build");
    cyc(ENDS);
    check("rst_build_no_commit", SW'(o_count), '0);

    // Reset during SPACE_PEND discards the pending word space.
    cyc(DOT); cyc(SPC);
    check("rst_pend_busy", SW'(o_busy), SW'(1));
    pulse_reset();
    check_zero_outputs("rst_pend");
    cyc(DOT);
    check("rst_pend_no_space", SW'(o_count), '0);
    cyc(CLR);

    // Strobe priority and Space in IDLE.
    cyc(DOT);
    cyc(ENDS | DASH);                                     exp_q.push_back(10'h100);
    cyc(DASH | DOT); cyc(ENDS);                           exp_q.push_back(10'h200);
    cyc(SPC);                                             exp_q.push_back(10'h3FF);
    check("prio_idle_space_busy", SW'(o_busy), '0);
    check("prio_count", SW'(o_count), SW'(3));
    check_store("prio");
    cyc(DOT);
    cyc(ENT | ENDS | DASH);
    check("prio_enter_valid", SW'(o_valid), SW'(1));
    check("prio_enter_commit", SW'(o_count), SW'(4));
    check("prio_enter_slot3", SW'(slot(3)), SW'(10'h100));
    cyc(CLR | ENT | DOT);
    check("prio_clear_valid", SW'(o_valid), '0);
    check("prio_clear_count", SW'(o_count), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
